// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Access codes, controller states and size/alignment helpers.
// Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [3:0] {
        RW_LB  = 4'b1000,
        RW_LH  = 4'b1001,
        RW_LW  = 4'b1010,
        RW_SB  = 4'b1011,
        RW_LBU = 4'b1100,
        RW_LHU = 4'b1101,
        RW_SH  = 4'b1110,
        RW_SW  = 4'b1111
    } rw_code_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    function automatic size_e access_size(input rw_code_e code);
        size_e sz;
        case (code)
            RW_LB, RW_LBU, RW_SB: sz = SZ_BYTE;
            RW_LH, RW_LHU, RW_SH: sz = SZ_HALF;
            default:              sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_store(input rw_code_e code);
        return (code == RW_SB) || (code == RW_SH) || (code == RW_SW);
    endfunction

    function automatic logic is_misaligned(input rw_code_e code, input logic [1:0] off);
        logic mis;
        case (access_size(code))
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Byte enables, store lane replication and load extraction/extension.
// Revision : 1.0  initial release
// ============================================================================
module lsu_align
    import mem_pkg::*;
(
    input  rw_code_e    i_code,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic        w_unsigned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_unsigned = (i_code == RW_LBU) || (i_code == RW_LHU);
    assign w_byte     = i_rdata[{i_offset, 3'b000} +: 8];
    assign w_half     = i_rdata[{i_offset[1], 4'b0000} +: 16];

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        case (access_size(i_code))
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = w_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_be    = 4'b0011 << {i_offset[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = w_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Single-outstanding load/store controller with gnt/rvalid timeout.
// Revision : 1.0  initial release
// ============================================================================
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int                 c_cnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    state_e             r_state;
    rw_code_e           r_code;
    logic [1:0]         r_off;
    logic [c_cnt_w-1:0] r_cnt;

    rw_code_e    w_code_in;
    rw_code_e    w_align_code;
    logic [1:0]  w_align_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata_ext;

    assign w_code_in = rw_code_e'(rw);

    // The aligner serves the incoming instruction in IDLE and the captured one afterwards.
    assign w_align_code = (r_state == ST_IDLE) ? w_code_in  : r_code;
    assign w_align_off  = (r_state == ST_IDLE) ? addr[1:0]  : r_off;

    lsu_align u_lsu_align (
        .i_code   (w_align_code),
        .i_offset (w_align_off),
        .i_wdata  (wdata),
        .i_rdata  (mem_rdata),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_rdata  (w_rdata_ext)
    );

    assign stall = ((r_state == ST_IDLE) && rw[3]) || (r_state == ST_REQ) || (r_state == ST_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_code    <= RW_LB;
            r_off     <= 2'b00;
            r_cnt     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rw[3]) begin
                        if (is_misaligned(w_code_in, addr[1:0])) begin
                            r_state <= ST_ERR;
                            done    <= 1'b1;
                            err     <= 1'b1;
                            rdata   <= '0;
                        end else begin
                            r_state   <= ST_REQ;
                            r_code    <= w_code_in;
                            r_off     <= addr[1:0];
                            r_cnt     <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store(w_code_in);
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= w_be;
                            mem_wdata <= w_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    // A grant on the final counted cycle still completes the access.
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        r_cnt   <= '0;
                        if (is_store(r_code)) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end else if (r_cnt == c_cnt_last) begin
                        mem_req <= 1'b0;
                        r_state <= ST_ERR;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        rdata   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        rdata   <= w_rdata_ext;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= ST_ERR;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        rdata   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE, ST_ERR: begin
                    r_state <= ST_IDLE;
                    done    <= 1'b0;
                    err     <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    done    <= 1'b0;
                    err     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Self-checking bench: vector table plus timeout/reset sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall, done, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .rw         (rw),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_maddr;
        logic [31:0] exp_mwdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic        chk_rd;
    } exp_t;

    localparam logic [3:0] LB = 4'b1000, LH = 4'b1001, LW = 4'b1010, SB = 4'b1011;
    localparam logic [3:0] LBU = 4'b1100, LHU = 4'b1101, SH = 4'b1110, SW = 4'b1111;

    exp_t sb_q[$];
    vec_t vecs[14];
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic is_st(input logic [3:0] c);
        return (c == SB) || (c == SH) || (c == SW);
    endfunction

    // Scoreboard: every completion pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_err", {31'd0, err}, {31'd0, e.err});
                if (e.chk_rd) check("sb_rdata", rdata, e.rdata);
            end
        end
        if (!rst && err && !done) check("err_without_done", {31'd0, done}, 32'd1);
    end

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_done_seen"}, {31'd0, done}, 32'd1);
        rw = 4'b0000;
        @(negedge clk);
    endtask

    task automatic push_exp(input logic e_err, input logic [31:0] e_rd, input logic chk);
        exp_t e;
        e.err = e_err; e.rdata = e_rd; e.chk_rd = chk;
        sb_q.push_back(e);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int n = 0;
        @(negedge clk);
        rw = v.rw; addr = v.addr; wdata = v.wdata;
        push_exp(v.exp_err, v.exp_rdata, v.exp_err || !is_st(v.rw));
        @(negedge clk);
        if (v.exp_err) begin
            check($sformatf("v%0d_noreq", i), {31'd0, mem_req}, 32'd0);
        end else begin
            while (!mem_req && n < 10) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("v%0d_req", i), {31'd0, mem_req}, 32'd1);
            check($sformatf("v%0d_be", i), {28'd0, mem_be}, {28'd0, v.exp_be});
            check($sformatf("v%0d_maddr", i), mem_addr, v.exp_maddr);
            check($sformatf("v%0d_we", i), {31'd0, mem_we}, {31'd0, is_st(v.rw)});
            if (is_st(v.rw)) check($sformatf("v%0d_mwdata", i), mem_wdata, v.exp_mwdata);
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            if (!is_st(v.rw)) begin
                mem_rvalid = 1'b1;
                mem_rdata  = v.mrdata;
                @(negedge clk);
                mem_rvalid = 1'b0;
                mem_rdata  = 32'hDEAD_0000;
            end
        end
        wait_done($sformatf("v%0d", i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int sc, k;
        //          rw   addr          wdata         mrdata        err  be       maddr         mwdata        rdata
        vecs[0]  = '{SW,  32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 4'b1111, 32'h100, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{LB,  32'h203, 32'h0,        32'h80123456, 1'b0, 4'b1000, 32'h200, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{LBU, 32'h203, 32'h0,        32'h80123456, 1'b0, 4'b1000, 32'h200, 32'h0,        32'h00000080};
        vecs[3]  = '{SH,  32'h102, 32'h00001234, 32'h0,        1'b0, 4'b1100, 32'h100, 32'h12341234, 32'h0};
        vecs[4]  = '{LW,  32'h101, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,   32'h0,        32'h0};
        vecs[5]  = '{LH,  32'h002, 32'h0,        32'hABCD1234, 1'b0, 4'b1100, 32'h000, 32'h0,        32'hFFFFABCD};
        vecs[6]  = '{LHU, 32'h000, 32'h0,        32'hABCD8765, 1'b0, 4'b0011, 32'h000, 32'h0,        32'h00008765};
        vecs[7]  = '{SB,  32'h301, 32'h000000A5, 32'h0,        1'b0, 4'b0010, 32'h300, 32'hA5A5A5A5, 32'h0};
        vecs[8]  = '{LW,  32'h400, 32'h0,        32'hCAFEF00D, 1'b0, 4'b1111, 32'h400, 32'h0,        32'hCAFEF00D};
        vecs[9]  = '{SH,  32'h103, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,   32'h0,        32'h0};
        vecs[10] = '{LH,  32'h005, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,   32'h0,        32'h0};
        vecs[11] = '{LB,  32'h001, 32'h0,        32'h00007F00, 1'b0, 4'b0010, 32'h000, 32'h0,        32'h0000007F};
        vecs[12] = '{SW,  32'h102, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,   32'h0,        32'h0};
        vecs[13] = '{LHU, 32'h006, 32'h0,        32'hFFEE0000, 1'b0, 4'b1100, 32'h004, 32'h0,        32'h0000FFEE};

        rst = 1'b1; rw = 4'b0; addr = '0; wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Store with grant in the first request cycle: two stall cycles, done right after.
        @(negedge clk);
        rw = SW; addr = 32'h100; wdata = 32'hDEADBEEF;
        push_exp(1'b0, 32'h0, 1'b0);
        sc = 0;
        #1 if (stall) sc++;
        @(negedge clk);
        if (stall) sc++;
        check("sw_req", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        if (stall) sc++;
        check("sw_done_after_gnt", {31'd0, done}, 32'd1);
        check("sw_stall_cycles", sc, 32'd2);
        wait_done("sw");

        // No grant: request held for exactly TIMEOUT cycles, then an error pulse.
        @(negedge clk);
        rw = LW; addr = 32'h10;
        push_exp(1'b1, 32'h0, 1'b1);
        @(negedge clk);
        k = 0;
        while (mem_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("req_timeout_cycles", k, 32'd4);
        check("req_timeout_err", {31'd0, err}, 32'd1);
        wait_done("req_to");

        // Grant on the last allowed cycle beats the timeout.
        @(negedge clk);
        rw = SW; addr = 32'h80; wdata = 32'h1;
        push_exp(1'b0, 32'h0, 1'b0);
        repeat (4) @(negedge clk);
        check("late_gnt_req", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("late_gnt_no_err", {31'd0, err}, 32'd0);
        wait_done("late_gnt");

        // Load never answered: error four cycles after entering WAIT.
        @(negedge clk);
        rw = LH; addr = 32'h200;
        push_exp(1'b1, 32'h0, 1'b1);
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("wait_timeout_cycles", k, 32'd4);
        check("wait_timeout_err", {31'd0, err}, 32'd1);
        wait_done("wait_to");

        // Reset during REQ drops the request without a clock edge.
        @(negedge clk);
        rw = LW; addr = 32'h40;
        @(negedge clk);
        check("rreq_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1; rw = 4'b0;
        #1;
        check("rreq_req_drop", {31'd0, mem_req}, 32'd0);
        check("rreq_addr_clr", mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset during WAIT abandons the load; a late rvalid is ignored.
        @(negedge clk);
        rw = LW; addr = 32'h44;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; rw = 4'b0;
        check("rwait_stall", {31'd0, stall}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rwait_stall_clr", {31'd0, stall}, 32'd0);
        check("rwait_be_clr", {28'd0, mem_be}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check("rwait_no_done", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        check("rwait_rdata_kept", rdata, 32'd0);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 64, is the number of cycles waited for mem_gnt or mem_rvalid before the access aborts with err.
REQ-002 Single clock; reset asynchronous, active-high.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 rw  in  4  access code from decode; bit3=1 means access. Codes: 1000 LB, 1001 LH, 1010 LW, 1100 LBU, 1101 LHU, 1011 SB, 1110 SH, 1111 SW.
REQ-006 addr  in  32  byte address.
REQ-007 wdata  in  32  store data, taken from the low bits.
REQ-008 stall  out  1  holds the pipeline while an access is in progress.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 err  out  1  one-cycle misalign/timeout pulse, coincident with done.
REQ-011 rdata  out  32  extended load result, valid while done=1.
REQ-012 mem_req  out  1  bus request.
REQ-013 mem_we  out  1  1 = store.
REQ-014 mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-015 mem_be  out  4  byte enables.
REQ-016 mem_wdata  out  32  lane-replicated store data.
REQ-017 mem_gnt  in  1  request accepted.
REQ-018 mem_rvalid  in  1  load data valid.
REQ-019 mem_rdata  in  32  load data.

Function
REQ-020 FSM states: IDLE, REQ, WAIT, DONE, ERR.
REQ-021 In IDLE, if rw[3]=1 and the access is aligned: capture rw/addr/wdata and go to REQ.
REQ-022 In IDLE, if rw[3]=1 and the access is misaligned: go to ERR. Misaligned means half (LH/LHU/SH) with addr[0]=1, or word with addr[1:0]!=0.
REQ-023 stall = (IDLE and rw[3]) or REQ or WAIT, combinational; stall=0 in DONE and ERR.
REQ-024 mem_req is registered.
  - It is 1 for every cycle in REQ, and only in REQ.
  - mem_we, mem_addr, mem_be and mem_wdata are stable while mem_req=1.
REQ-025 REQ with mem_gnt=1: a store goes to DONE, a load goes to WAIT.
REQ-026 WAIT with mem_rvalid=1: latch the extended data and go to DONE; mem_rvalid outside WAIT is ignored.
REQ-027 DONE: done=1 for one cycle, then IDLE; the pipeline advances on this edge, so IDLE samples the next instruction.
REQ-028 ERR: done=1 and err=1 for one cycle, rdata=0, no bus request issued, then IDLE.
REQ-029 A cycle counter clears on entry to REQ and WAIT and increments each cycle there.
  - When it reaches TIMEOUT-1 without the awaited gnt/rvalid, go to ERR and drop mem_req.
  - mem_gnt or mem_rvalid in that same cycle wins over the timeout.
REQ-030 Byte enables:
  - Byte access: mem_be = 0001 << addr[1:0].
  - Half access: mem_be = 0011 << {addr[1],1'b0}.
  - Word access: mem_be = 1111.
REQ-031 Store data is replicated across lanes: SB → {4{wdata[7:0]}}, SH → {2{wdata[15:0]}}, SW → wdata.
REQ-032 Load data: select the byte or half at the captured offset, then:
  - LB/LH sign-extend to 32 bits.
  - LBU/LHU zero-extend to 32 bits.
  - LW passes the word through.
REQ-033 rdata holds its last value outside DONE/ERR.
REQ-034 Only one outstanding access; no new capture before returning to IDLE.

Reset
REQ-035 rst=1 forces, immediately and asynchronously:
  - state IDLE, counter 0;
  - mem_req, mem_we, done, err = 0;
  - mem_addr, mem_be, mem_wdata, rdata = 0.
REQ-036 Reset during REQ or WAIT abandons the access; a later mem_rvalid is ignored.

Structure
REQ-037 Package mem_pkg holds the rw code enum, the FSM state enum and the misalignment helper function.
REQ-038 Sub-module lsu_align (combinational) produces mem_be, mem_wdata and extended rdata from code, offset and data; one instance.

Verification
REQ-039 SW addr=0x100 wdata=0xDEADBEEF, gnt one cycle after mem_req → mem_be=1111, mem_addr=0x100, done one cycle after gnt, stall high 2 cycles.
REQ-040 LB addr=0x203, mem_rdata=0x80xxxxxx → mem_be=1000, rdata=0xFFFFFF80; LBU same → 0x00000080.
REQ-041 SH addr=0x102 wdata=0x1234 → mem_be=1100, mem_wdata=0x12341234.
REQ-042 LW addr=0x101 → no mem_req, done=err=1 next cycle, rdata=0.
REQ-043 LH with rvalid never asserted, TIMEOUT=4 → err pulse 4 cycles after entering WAIT; rst asserted mid-WAIT → mem_req=0 immediately, late rvalid ignored.
